// File: rtl/profiler_pkg.sv
// Shared definitions for the event-profiling counters: count-mode encoding
// and default sizing constants.
package profiler_pkg;

  typedef enum logic {
    MODE_EDGE  = 1'b0,
    MODE_LEVEL = 1'b1
  } cnt_mode_e;

  localparam int DEF_CNT_W    = 32;
  localparam int DEF_INTERVAL = 2000000;

endpackage

// File: rtl/event_counter_channel.sv
// One event channel: edge/level detection, saturating or wrapping increment,
// sticky overflow flag. Exposes this cycle's post-increment value for snapshots.
module event_counter_channel
  import profiler_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  cnt_mode_e        i_mode,
  input  logic             i_evt,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_snap_cnt,
  output logic             o_snap_ovf
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_inc;
  logic             w_full;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  assign w_inc  = i_evt & ((i_mode == MODE_LEVEL) | ~r_prev);
  assign w_full = &r_cnt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_inc) begin
      if (!w_full)             w_cnt_nxt = r_cnt + ONE;
      else if (SATURATE == 0)  w_cnt_nxt = '0;
    end
  end

  assign w_ovf_nxt  = r_ovf | (w_inc & w_full);
  assign o_snap_cnt = w_cnt_nxt;
  assign o_snap_ovf = w_ovf_nxt;

  // prev keeps tracking the raw strobe even on a clearing cycle so edges stay exact
  always_ff @(posedge clk) begin
    if (rst || !i_enable) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_prev <= i_evt;
      if (i_clear) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
      end
    end
  end

endmodule

// File: rtl/multi_event_counter.sv
// Multi-channel event profiler: per-channel live counters plus a periodic or
// on-demand snapshot of all counts and overflow flags.
module multi_event_counter
  import profiler_pkg::*;
#(
  parameter int NUM_CH        = 9,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int INTERVAL      = DEF_INTERVAL,
  parameter int SATURATE      = 1,
  parameter int CLEAR_ON_SNAP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       events,
  input  logic                    snap_req,
  output logic [NUM_CH*CNT_W-1:0] counts_o,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic                    snap_valid
);

  localparam int             IW   = $clog2(INTERVAL);
  localparam logic [IW-1:0]  TERM = IW'(INTERVAL - 1);

  logic [IW-1:0]                   r_int;
  logic                            w_term;
  logic                            w_trig;
  logic                            w_clear;
  logic [NUM_CH-1:0][CNT_W-1:0]    w_snap_cnt;
  logic [NUM_CH-1:0]               w_snap_ovf;

  assign w_term  = (r_int == TERM);
  assign w_trig  = enable & (w_term | snap_req);
  assign w_clear = w_trig & (CLEAR_ON_SNAP != 0);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    event_counter_channel #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_enable   (enable),
      .i_mode     (cnt_mode_e'(mode[k])),
      .i_evt      (events[k]),
      .i_clear    (w_clear),
      .o_snap_cnt (w_snap_cnt[k]),
      .o_snap_ovf (w_snap_ovf[k])
    );
  end

  // Snapshot captures the channels' next values so a trigger-cycle event is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int      <= '0;
      counts_o   <= '0;
      ovf_o      <= '0;
      snap_valid <= 1'b0;
    end else if (!enable) begin
      r_int      <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= w_trig;
      if (w_trig) begin
        r_int    <= '0;
        counts_o <= w_snap_cnt;
        ovf_o    <= w_snap_ovf;
      end else begin
        r_int    <= r_int + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_event_counter.sv
// Directed bench: four DUT copies share stimulus (main, cumulative, saturating
// and wrapping at INTERVAL=32); each task checks its own scenario inline.
module tb_multi_event_counter;

  logic        clk = 1'b0;
  logic        rst, enable, snap_req;
  logic [3:0]  mode, events;

  logic [15:0] cnt_a, cnt_c, cnt_s, cnt_w;
  logic [3:0]  ovf_a, ovf_c, ovf_s, ovf_w;
  logic        sv_a, sv_c, sv_s, sv_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_event_counter #(.NUM_CH(4), .CNT_W(4), .INTERVAL(10), .SATURATE(1), .CLEAR_ON_SNAP(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .events(events), .snap_req(snap_req),
    .counts_o(cnt_a), .ovf_o(ovf_a), .snap_valid(sv_a));
  multi_event_counter #(.NUM_CH(4), .CNT_W(4), .INTERVAL(10), .SATURATE(1), .CLEAR_ON_SNAP(0)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .events(events), .snap_req(snap_req),
    .counts_o(cnt_c), .ovf_o(ovf_c), .snap_valid(sv_c));
  multi_event_counter #(.NUM_CH(4), .CNT_W(4), .INTERVAL(32), .SATURATE(1), .CLEAR_ON_SNAP(1)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .events(events), .snap_req(snap_req),
    .counts_o(cnt_s), .ovf_o(ovf_s), .snap_valid(sv_s));
  multi_event_counter #(.NUM_CH(4), .CNT_W(4), .INTERVAL(32), .SATURATE(0), .CLEAR_ON_SNAP(1)) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .events(events), .snap_req(snap_req),
    .counts_o(cnt_w), .ovf_o(ovf_w), .snap_valid(sv_w));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; events = '0; snap_req = 1'b0; mode = '0;
    tick(); tick();
    rst = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; snap_req = 1'b1; events = '1; mode = '0;
    tick();
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL reset_snap_valid: got %b expected 0", sv_a); end
    n_chk++; if (cnt_a !== 16'h0000) begin n_fail++; $display("FAIL reset_counts: got %h expected 0000", cnt_a); end
    n_chk++; if (ovf_a !== 4'h0) begin n_fail++; $display("FAIL reset_ovf: got %h expected 0", ovf_a); end
    n_chk++; if (sv_s !== 1'b0) begin n_fail++; $display("FAIL reset_snap_valid_s: got %b expected 0", sv_s); end
    do_reset();
  endtask

  task automatic test_edge();
    do_reset();
    mode = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      events = (i inside {0, 1, 2, 5, 6, 7}) ? 4'b0001 : 4'b0000;
      tick();
      if (i < 9) begin
        n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL edge_early_pulse: cycle %0d got %b expected 0", i, sv_a); end
      end
    end
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL edge_snap_valid: got %b expected 1", sv_a); end
    n_chk++; if (cnt_a !== 16'h0002) begin n_fail++; $display("FAIL edge_count: got %h expected 0002", cnt_a); end
    n_chk++; if (ovf_a !== 4'h0) begin n_fail++; $display("FAIL edge_ovf: got %h expected 0", ovf_a); end
    events = '0;
    tick();
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL edge_pulse_width: got %b expected 0", sv_a); end
    n_chk++; if (cnt_a !== 16'h0002) begin n_fail++; $display("FAIL edge_hold: got %h expected 0002", cnt_a); end
  endtask

  task automatic test_level();
    do_reset();
    mode = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      events = (i < 5) ? 4'b0010 : 4'b0000;
      tick();
    end
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL level_snap_valid: got %b expected 1", sv_a); end
    n_chk++; if (cnt_a !== 16'h0050) begin n_fail++; $display("FAIL level_count5: got %h expected 0050", cnt_a); end
    n_chk++; if (cnt_c !== 16'h0050) begin n_fail++; $display("FAIL level_cum5: got %h expected 0050", cnt_c); end
    for (int i = 0; i < 10; i++) begin
      events = 4'b0010;
      tick();
    end
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL level_snap_valid2: got %b expected 1", sv_a); end
    n_chk++; if (cnt_a !== 16'h00A0) begin n_fail++; $display("FAIL level_count10: got %h expected 00a0", cnt_a); end
    n_chk++; if (cnt_c !== 16'h00F0) begin n_fail++; $display("FAIL level_cum15: got %h expected 00f0", cnt_c); end
    n_chk++; if (ovf_c !== 4'h0) begin n_fail++; $display("FAIL level_cum_ovf: got %h expected 0", ovf_c); end
  endtask

  task automatic test_saturate();
    int pulses;
    do_reset();
    mode = 4'b0100;
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      events = (i < 20) ? 4'b0100 : 4'b0000;
      tick();
      if (i < 31 && sv_s) pulses++;
    end
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL sat_early_pulses: got %0d expected 0", pulses); end
    n_chk++; if (sv_s !== 1'b1) begin n_fail++; $display("FAIL sat_snap_valid: got %b expected 1", sv_s); end
    n_chk++; if (cnt_s !== 16'h0F00) begin n_fail++; $display("FAIL sat_count: got %h expected 0f00", cnt_s); end
    n_chk++; if (ovf_s !== 4'b0100) begin n_fail++; $display("FAIL sat_ovf: got %b expected 0100", ovf_s); end
    n_chk++; if (cnt_w !== 16'h0400) begin n_fail++; $display("FAIL wrap_count: got %h expected 0400", cnt_w); end
    n_chk++; if (ovf_w !== 4'b0100) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0100", ovf_w); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (ovf_s !== 4'h0) begin n_fail++; $display("FAIL sat_rst_ovf: got %b expected 0000", ovf_s); end
    n_chk++; if (cnt_w !== 16'h0000) begin n_fail++; $display("FAIL wrap_rst_count: got %h expected 0000", cnt_w); end
  endtask

  task automatic test_snap_req();
    int pulses;
    do_reset();
    mode = 4'b0000;
    tick();
    events = 4'b0001; tick();
    events = 4'b0000; tick();
    snap_req = 1'b1; tick();
    snap_req = 1'b0;
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL req_snap_valid: got %b expected 1", sv_a); end
    n_chk++; if (cnt_a !== 16'h0001) begin n_fail++; $display("FAIL req_count: got %h expected 0001", cnt_a); end
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (sv_a) pulses++;
    end
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL req_gap_pulses: got %0d expected 0", pulses); end
    tick();
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL req_next_auto: got %b expected 1", sv_a); end
    n_chk++; if (cnt_a !== 16'h0000) begin n_fail++; $display("FAIL req_auto_count: got %h expected 0000", cnt_a); end
    for (int i = 0; i < 9; i++) tick();
    snap_req = 1'b1; tick();
    snap_req = 1'b0;
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL req_on_terminal: got %b expected 1", sv_a); end
    tick();
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL req_terminal_single: got %b expected 0", sv_a); end
    for (int i = 0; i < 8; i++) tick();
    tick();
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL req_terminal_restart: got %b expected 1", sv_a); end
  endtask

  task automatic test_disable();
    int pulses;
    do_reset();
    mode = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      events = (i == 0 || i == 2) ? 4'b0001 : 4'b0000;
      tick();
    end
    n_chk++; if (cnt_a !== 16'h0002) begin n_fail++; $display("FAIL dis_first_snap: got %h expected 0002", cnt_a); end
    for (int i = 0; i < 5; i++) begin
      events = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    enable = 1'b0; events = '0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      snap_req = (i == 2);
      events = (i >= 4) ? 4'b0001 : 4'b0000;
      tick();
      if (sv_a) pulses++;
    end
    snap_req = 1'b0;
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL dis_pulses: got %0d expected 0", pulses); end
    n_chk++; if (cnt_a !== 16'h0002) begin n_fail++; $display("FAIL dis_hold: got %h expected 0002", cnt_a); end
    enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL reen_snap_valid: got %b expected 1", sv_a); end
    n_chk++; if (cnt_a !== 16'h0001) begin n_fail++; $display("FAIL reen_count: got %h expected 0001", cnt_a); end
  endtask

  task automatic test_rst_mid();
    int pulses;
    do_reset();
    mode = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      events = (i == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    n_chk++; if (cnt_a !== 16'h0001) begin n_fail++; $display("FAIL rmid_pre_snap: got %h expected 0001", cnt_a); end
    for (int i = 0; i < 7; i++) begin
      events = (i == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    rst = 1'b1; tick();
    rst = 1'b0;
    n_chk++; if (cnt_a !== 16'h0000) begin n_fail++; $display("FAIL rmid_counts: got %h expected 0000", cnt_a); end
    n_chk++; if (ovf_a !== 4'h0) begin n_fail++; $display("FAIL rmid_ovf: got %h expected 0", ovf_a); end
    n_chk++; if (sv_a !== 1'b0) begin n_fail++; $display("FAIL rmid_snap_valid: got %b expected 0", sv_a); end
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (sv_a) pulses++;
    end
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL rmid_early_pulses: got %0d expected 0", pulses); end
    tick();
    n_chk++; if (sv_a !== 1'b1) begin n_fail++; $display("FAIL rmid_first_snap: got %b expected 1", sv_a); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; snap_req = 1'b0; mode = '0; events = '0;
    test_reset();
    test_edge();
    test_level();
    test_saturate();
    test_snap_req();
    test_disable();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_event_counter.md
MULTI_EVENT_COUNTER -- requirements
Module: multi_event_counter

Interface
REQ-001 Parameter NUM_CH, default 9: number of independent event channels, 1..32.
REQ-002 Parameter CNT_W, default 32: counter width in bits, 4..64.
REQ-003 Parameter INTERVAL, default 2000000: automatic snapshot period in clk cycles, >=2.
REQ-004 Parameter SATURATE, default 1: 1 = counters saturate at all-ones; 0 = counters wrap.
REQ-005 Parameter CLEAR_ON_SNAP, default 1: 1 = live counters restart from 0 after each snapshot; 0 = live counters are cumulative.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  1 = counting active; 0 = live state cleared and held.
REQ-009 mode  input  NUM_CH  per-channel count mode: 0 = rising-edge count, 1 = level (cycles-high) count.
REQ-010 events  input  NUM_CH  raw event strobes, synchronous to clk.
REQ-011 snap_req  input  1  single-cycle manual snapshot request.
REQ-012 counts_o  output  NUM_CH*CNT_W  snapshot counts; channel k at bits [k*CNT_W +: CNT_W].
REQ-013 ovf_o  output  NUM_CH  snapshot per-channel overflow flags.
REQ-014 snap_valid  output  1  one-cycle pulse, coincident with the first cycle of updated counts_o/ovf_o.

Function
REQ-015 Edge mode: channel increments on any cycle with events[k]=1 and prev[k]=0; prev[k] registers events[k] every enabled cycle, in both modes.
REQ-016 Level mode: channel increments on every enabled cycle with events[k]=1.
REQ-017 Mode change takes effect on the cycle it is sampled; no counter clear.
REQ-018 Interval counter runs 0..INTERVAL-1 while enabled; the cycle at INTERVAL-1 is the terminal cycle.
REQ-019 Snapshot trigger = terminal cycle OR snap_req, while enable=1; simultaneous terminal and snap_req produce exactly one snapshot.
REQ-020 On a trigger cycle, each channel's snapshot value = live count including that cycle's increment (no event lost); counts_o, ovf_o and snap_valid update on the next rising edge.
REQ-021 On a trigger cycle, interval counter returns to 0; with CLEAR_ON_SNAP=1, live counters and live overflow flags become 0.
REQ-022 With CLEAR_ON_SNAP=0, live counters continue; live overflow flags are sticky until reset or enable=0.
REQ-023 Increment at all-ones: SATURATE=1 holds at 2^CNT_W-1; SATURATE=0 wraps to 0; both set the channel's live overflow flag.
REQ-024 snap_valid is low on all cycles other than the cycle after a trigger; back-to-back triggers give back-to-back pulses.
REQ-025 enable=0: live counters, prev, overflow flags and interval counter cleared to 0; counts_o/ovf_o retain their last values; snap_req ignored; snap_valid=0.
REQ-026 Because prev is 0 on the first enabled cycle, an event already high at re-enable counts as one edge.

Reset
REQ-027 rst=1 at a clock edge: counts_o=0, ovf_o=0, snap_valid=0, live counters=0, prev=0, overflow flags=0, interval counter=0; rst has priority over enable and snap_req.
REQ-028 rst asserted mid-interval discards any pending snapshot; first snapshot after release occurs INTERVAL cycles after the first enabled cycle.

Structure
REQ-029 Shared package profiler_pkg holds the count-mode enum (MODE_EDGE=0, MODE_LEVEL=1) and the default CNT_W/INTERVAL constants.
REQ-030 One sub-module, event_counter_channel (prev register, increment, saturate/wrap, overflow flag, clear), instantiated NUM_CH times by generate; interval counter and snapshot registers stay in the top level.

Verification (NUM_CH=4, CNT_W=4, INTERVAL=10 unless noted)
REQ-031 Edge mode ch0: two 3-cycle-high pulses within one interval -> snap_valid pulse once, ch0 count = 2, ovf_o[0]=0.
REQ-032 Level mode ch1 high for 5 cycles in one interval -> ch1 count = 5; ch1 held high across the next full interval -> 10.
REQ-033 INTERVAL=32, level mode ch2 high 20 cycles: SATURATE=1 -> count 15, ovf_o[2]=1; SATURATE=0 -> count 4, ovf_o[2]=1.
REQ-034 snap_req at interval cycle 3 -> snap_valid on the following cycle, next auto snapshot 10 cycles after the request; snap_req on terminal cycle -> single pulse.
REQ-035 enable dropped at interval cycle 5 with count 3 -> no snap_valid, counts_o unchanged; re-enable with events[0] already high -> ch0 counts 1 in edge mode.
REQ-036 rst at interval cycle 7 -> next cycle counts_o=0, ovf_o=0, snap_valid=0; next snap_valid 10 enabled cycles after release.
